// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory: access sizes,
// controller states and the load extension helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } dmem_state_e;

  function automatic logic [31:0] extend16(input logic [15:0] val, input logic sx);
    return sx ? {{16{val[15]}}, val} : {16'h0000, val};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: merges store data into the old word and
// extracts/extends the addressed lane for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // select the addressed byte and half of the current word
  always_comb begin
    byte_s = 8'h00;
    case (lane)
      2'd0:    byte_s = old_word[7:0];
      2'd1:    byte_s = old_word[15:8];
      2'd2:    byte_s = old_word[23:16];
      2'd3:    byte_s = old_word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = old_word[31:16];
    end else begin
      half_s = old_word[15:0];
    end
  end

  // store merge keeps untouched lanes; loads extend per sign_ext
  always_comb begin
    merged_word = old_word;
    load_data   = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged_word[7:0]   = wdata[7:0];
          2'd1:    merged_word[15:8]  = wdata[7:0];
          2'd2:    merged_word[23:16] = wdata[7:0];
          2'd3:    merged_word[31:24] = wdata[7:0];
          default: merged_word = old_word;
        endcase
        load_data = extend16({{8{byte_s[7] & sign_ext}}, byte_s}, sign_ext);
      end
      SZ_HALF: begin
        if (lane[1]) begin
          merged_word[31:16] = wdata[15:0];
        end else begin
          merged_word[15:0] = wdata[15:0];
        end
        load_data = extend16(half_s, sign_ext);
      end
      SZ_WORD: begin
        merged_word = wdata;
        load_data   = old_word;
      end
      default: begin
        merged_word = old_word;
        load_data   = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Word-organised data memory with byte/half/word access, programmable wait
// states, alignment/range fault detection and a zero-fill sweep after reset.
module byte_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault
);

  localparam int IW = $clog2(DEPTH);

  logic [31:0]   mem_r [DEPTH];
  dmem_state_e   state_r;
  logic [IW-1:0] clr_idx_r;
  logic [3:0]    cnt_r;
  logic          we_r;
  logic [1:0]    size_r;
  logic          sign_r;
  logic [IW-1:0] word_idx_r;
  logic [1:0]    lane_r;
  logic [31:0]   wdata_r;
  logic          flt_lat_r;
  logic [31:0]   res_r;
  logic          done_r;
  logic          fault_r;
  logic [31:0]   rdata_r;

  logic          acc_fault_s;
  logic          mem_we_s;
  logic [IW-1:0] mem_idx_s;
  logic [31:0]   mem_wdata_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   merged_s;
  logic [31:0]   load_s;

  assign ready = (state_r == ST_IDLE);
  assign done  = done_r;
  assign fault = fault_r;
  assign rdata = rdata_r;

  assign rd_word_s = mem_r[word_idx_r];

  dmem_lane_align u_align (
    .size        (size_r),
    .sign_ext    (sign_r),
    .lane        (lane_r),
    .wdata       (wdata_r),
    .old_word    (rd_word_s),
    .merged_word (merged_s),
    .load_data   (load_s)
  );

  // reject reserved size, misalignment and out-of-range word index
  always_comb begin
    acc_fault_s = 1'b0;
    if (size == SZ_RSVD) begin
      acc_fault_s = 1'b1;
    end else if ((size == SZ_HALF) && addr[0]) begin
      acc_fault_s = 1'b1;
    end else if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) begin
      acc_fault_s = 1'b1;
    end else if ({2'b00, addr[31:2]} >= 32'(DEPTH)) begin
      acc_fault_s = 1'b1;
    end else begin
      acc_fault_s = 1'b0;
    end
  end

  // single write port; gating with reset lets reset win over a store
  always_comb begin
    mem_we_s    = 1'b0;
    mem_idx_s   = clr_idx_r;
    mem_wdata_s = 32'h0000_0000;
    if (reset && (state_r == ST_CLEAR)) begin
      mem_we_s    = 1'b1;
      mem_idx_s   = clr_idx_r;
      mem_wdata_s = 32'h0000_0000;
    end else if (reset && (state_r == ST_ACCESS) && we_r) begin
      mem_we_s    = 1'b1;
      mem_idx_s   = word_idx_r;
      mem_wdata_s = merged_s;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // storage array
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= mem_wdata_s;
    end
  end

  // access controller
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_CLEAR;
      clr_idx_r  <= '0;
      cnt_r      <= 4'd0;
      done_r     <= 1'b0;
      fault_r    <= 1'b0;
      rdata_r    <= 32'h0000_0000;
      res_r      <= 32'h0000_0000;
      flt_lat_r  <= 1'b0;
      we_r       <= 1'b0;
      size_r     <= SZ_WORD;
      sign_r     <= 1'b0;
      word_idx_r <= '0;
      lane_r     <= 2'b00;
      wdata_r    <= 32'h0000_0000;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_CLEAR: begin
          clr_idx_r <= clr_idx_r + 1'b1;
          if (clr_idx_r == IW'(DEPTH - 1)) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (req) begin
            we_r       <= we;
            size_r     <= size;
            sign_r     <= sign_ext;
            word_idx_r <= addr[IW+1:2];
            lane_r     <= addr[1:0];
            wdata_r    <= wdata;
            res_r      <= 32'h0000_0000;
            flt_lat_r  <= acc_fault_s;
            if (acc_fault_s) begin
              state_r <= ST_RESP;
            end else if (WAIT_CYCLES == 0) begin
              state_r <= ST_ACCESS;
            end else begin
              cnt_r   <= 4'(WAIT_CYCLES);
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r <= 4'd1) begin
            state_r <= ST_ACCESS;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_ACCESS: begin
          if (!we_r) begin
            res_r <= load_s;
          end
          state_r <= ST_RESP;
        end
        ST_RESP: begin
          done_r  <= 1'b1;
          rdata_r <= res_r;
          fault_r <= flt_lat_r;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_idx_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_data_memory.sv
// Directed bench for byte_data_memory: a default instance (WAIT_CYCLES=2)
// and a small zero-wait instance share clock, reset and request fields.
module tb_byte_data_memory;
  import dmem_pkg::*;

  localparam int DEPTH  = 1024;
  localparam int DEPTH2 = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        req2 = 1'b0;
  logic        we = 1'b0;
  logic        sign_ext = 1'b0;
  logic [1:0]  size = SZ_WORD;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, done, fault, ready2, done2, fault2;
  logic [31:0] rdata, rdata2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  byte_data_memory #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata), .fault(fault)
  );

  byte_data_memory #(.DEPTH(DEPTH2), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req2), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready2), .done(done2), .rdata(rdata2), .fault(fault2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one request on instance sel (0 = default, 1 = zero-wait); call at a negedge
  task automatic run(input string tag, input bit sel, input logic w, input logic [1:0] sz,
                     input logic sx, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_flt, input int exp_lat);
    int g;
    int lat;
    logic [31:0] rd;
    logic flt;
    g = 0;
    while (!(sel ? ready2 : ready) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check({tag, ".ready"}, {31'b0, (sel ? ready2 : ready)}, 32'd1);
    we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    if (sel) req2 = 1'b1; else req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    req2 = 1'b0;
    lat = -1;
    rd = 32'hxxxx_xxxx;
    flt = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (sel ? done2 : done) begin
        lat = k;
        rd = sel ? rdata2 : rdata;
        flt = sel ? fault2 : fault;
        break;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".fault"}, {31'b0, flt}, {31'b0, exp_flt});
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int lowrun;
    int dones;
    int saw_done;

    // one reset edge, then count cycles until ready
    @(negedge clk);
    reset = 1'b1;
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.fault", {31'b0, fault}, 32'd0);
    check("rst.rdata", rdata, 32'h0);
    cnt = 0;
    while (!ready && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    check("rst.ready_low_cycles", 32'(cnt), 32'(DEPTH));

    run("ld_w000", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0,   32'h0, 32'h0, 1'b0, 4);
    run("ld_wffc", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'hFFC, 32'h0, 32'h0, 1'b0, 4);
    run("st_w10",  1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 4);
    run("st_b11",  1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h1234_56AA, 32'h0, 1'b0, 4);
    run("ld_w10",  1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h1122_AA44, 1'b0, 4);
    run("ld_b11s", 1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0, 4);
    run("ld_b11z", 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 32'h0000_00AA, 1'b0, 4);
    run("ld_h12s", 1'b0, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'h0000_1122, 1'b0, 4);
    run("ld_h10s", 1'b0, 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 32'hFFFF_AA44, 1'b0, 4);
    run("ld_w10x", 1'b0, 1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, 32'h1122_AA44, 1'b0, 4);

    // rejected accesses: one-edge response, array untouched
    run("f_h13",  1'b0, 1'b1, SZ_HALF, 1'b0, 32'h13, 32'h0000_BEEF, 32'h0, 1'b1, 1);
    repeat (3) @(negedge clk);
    check("f_hold.fault", {31'b0, fault}, 32'd1);
    run("f_w02",  1'b0, 1'b0, SZ_WORD, 1'b0, 32'h2,  32'h0, 32'h0, 1'b1, 1);
    run("f_rsvd", 1'b0, 1'b1, SZ_RSVD, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    run("f_oob",  1'b0, 1'b1, SZ_WORD, 1'b0, 32'(DEPTH * 4), 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    run("ld_w10f", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h1122_AA44, 1'b0, 4);

    run("st_h12",  1'b0, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'hABCD_7788, 32'h0, 1'b0, 4);
    run("st_b13",  1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h0000_005A, 32'h0, 1'b0, 4);
    run("ld_w10h", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h5A88_AA44, 1'b0, 4);

    // req held high: back-to-back accesses separated by WAIT_CYCLES+2 busy cycles
    we = 1'b0; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h10; req = 1'b1;
    lowrun = 0;
    dones = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        check("held.rdata", rdata, 32'h5A88_AA44);
      end
      if (!ready) begin
        lowrun++;
      end else begin
        check("held.gap", 32'(lowrun), 32'd4);
        lowrun = 0;
      end
    end
    req = 1'b0;
    check("held.dones", 32'(dones), 32'd4);
    @(negedge clk);

    // zero-wait instance
    run("d0_st_w04", 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h4, 32'h55AA_33CC, 32'h0, 1'b0, 2);
    run("d0_ld_w04", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 32'h55AA_33CC, 1'b0, 2);
    run("d0_ld_b06", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h6, 32'h0, 32'hFFFF_FFAA, 1'b0, 2);
    run("d0_f_oob",  1'b1, 1'b0, SZ_WORD, 1'b0, 32'(DEPTH2 * 4), 32'h0, 32'h0, 1'b1, 1);

    // reset lands on the ACCESS edge of a store
    we = 1'b1; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h20; wdata = 32'hDEAD_BEEF;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort.ready", {31'b0, ready}, 32'd0);
    cnt = 0;
    while (!ready && cnt < 5000) begin
      if (done) saw_done++;
      cnt++;
      @(negedge clk);
    end
    check("abort.no_done", 32'(saw_done), 32'd0);
    check("abort.clear_cycles", 32'(cnt), 32'(DEPTH));
    run("ld_w20_after", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 4);
    run("ld_w10_after", 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, word count (power of two, 64..8192).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, access wait states (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-005 SHALL have port req  input  1  access request.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port sign_ext  input  1  loads: 1 sign-extend, 0 zero-extend.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port ready  output  1  block can accept req this cycle.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rdata  output  32  load result, valid while done=1.
REQ-014 SHALL have port fault  output  1  access rejected, valid while done=1.

Function
REQ-015 SHALL implement FSM states CLEAR, IDLE, WAIT, ACCESS, RESP.
REQ-016 CLEAR: write zero to one word per cycle, index 0..DEPTH-1; ready=0; go to IDLE after index DEPTH-1.
REQ-017 IDLE: ready=1; on req=1, latch we/size/sign_ext/addr/wdata (the accept edge) and set ready=0 next cycle.
REQ-018 SHALL raise fault when size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= DEPTH.
REQ-019 Faulting accept: go to RESP directly; no array write; rdata=0; done=1, fault=1 one cycle after the accept edge.
REQ-020 Legal accept: go to WAIT with counter loaded to WAIT_CYCLES; go to ACCESS immediately when WAIT_CYCLES=0.
REQ-021 WAIT: decrement the counter each cycle; go to ACCESS when it reaches 1.
REQ-022 ACCESS: stores SHALL write only the addressed lane(s), byte lane=addr[1:0], half lane=addr[1]; other bytes keep their values.
REQ-023 ACCESS: loads SHALL register the extracted lane, extended per sign_ext (word ignores sign_ext); stores return rdata=0.
REQ-024 RESP: done=1 for exactly one cycle; then IDLE; legal done occurs WAIT_CYCLES+2 edges after accept.
REQ-025 req while ready=0 SHALL be ignored, with no queuing.
REQ-026 rdata and fault SHALL hold their value from the last RESP until the next RESP.

Reset
REQ-027 reset=0 at an edge SHALL force CLEAR with index 0 and counter 0, and set ready=0, done=0, fault=0, rdata=0.
REQ-028 reset=0 at an ACCESS edge SHALL suppress that store (reset wins); an in-flight access is aborted with no done.
REQ-029 Array contents become all-zero only through CLEAR; ready first rises DEPTH cycles after reset deassertion.

Structure
REQ-030 Shared package dmem_pkg SHALL hold the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD) and the FSM state enum.
REQ-031 Combinational sub-module dmem_lane_align SHALL perform store lane merge and load extract/extend; the array and FSM stay in byte_data_memory.

Verification
REQ-032 Reset low 1 cycle then high -> ready=0 for exactly DEPTH cycles, then 1; word loads at 0x0 and 0xFFC return 0.
REQ-033 Word store 0x11223344 @0x10, byte store 0xAA @0x11, then load word @0x10 -> rdata=0x1122AA44, done 4 edges after accept (WAIT_CYCLES=2).
REQ-034 After REQ-033: load byte @0x11 sign_ext=1 -> 0xFFFFFFAA; sign_ext=0 -> 0x000000AA; half @0x12 sign_ext=1 -> 0x00001122.
REQ-035 Half store @0x13, word load @0x2, size=11, and addr=DEPTH*4 -> each gives fault=1, done 1 edge after accept, memory unchanged.
REQ-036 Store 0xDEADBEEF @0x20 with reset pulled low at the ACCESS edge -> no done; after CLEAR, load @0x20 returns 0.
REQ-037 req held high continuously -> one access per completion, ready low WAIT_CYCLES+2 cycles between accepts; WAIT_CYCLES=0 -> done 2 edges after accept.
